// File: rtl/dram_arbiter.sv
// dram_arbiter: round-robin sharing of the data RAM port between the core
// load/store path (master 0) and a secondary debug/DMA master (master 1).
// Outstanding reads are tracked in an in-order ID FIFO so that each RAM read
// response is steered back to the master that issued the load.
module dram_arbiter #(
  parameter int XLEN            = 32,
  parameter int MAX_OUTSTANDING = 4,
  parameter int CNT_W           = $clog2(MAX_OUTSTANDING) + 1
) (
  input  logic                clk,
  input  logic                rst_b,
  // master 0 (core load/store path)
  input  logic                m0_req,
  input  logic                m0_write,
  input  logic [XLEN-1:0]     m0_addr,
  input  logic [XLEN-1:0]     m0_wdata,
  input  logic [XLEN/8-1:0]   m0_wstrb,
  output logic                m0_ready,
  output logic                m0_rvalid,
  output logic [XLEN-1:0]     m0_rdata,
  // master 1 (debug / DMA)
  input  logic                m1_req,
  input  logic                m1_write,
  input  logic [XLEN-1:0]     m1_addr,
  input  logic [XLEN-1:0]     m1_wdata,
  input  logic [XLEN/8-1:0]   m1_wstrb,
  output logic                m1_ready,
  output logic                m1_rvalid,
  output logic [XLEN-1:0]     m1_rdata,
  // data RAM port
  output logic                dram_req,
  output logic                dram_write,
  output logic [XLEN-1:0]     dram_addr,
  output logic [XLEN-1:0]     dram_wdata,
  output logic [XLEN/8-1:0]   dram_wstrb,
  input  logic                dram_ready,
  input  logic                dram_rvalid,
  input  logic [XLEN-1:0]     dram_rdata,
  // status
  output logic [CNT_W-1:0]    outstanding,
  output logic                err_unexp_rsp
);

  localparam int               AW       = $clog2(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(MAX_OUTSTANDING);

  // Pointers carry one extra MSB so that full and empty are distinguishable.
  logic [CNT_W-1:0]           wptr_q, wptr_d;
  logic [CNT_W-1:0]           rptr_q, rptr_d;
  logic [MAX_OUTSTANDING-1:0] id_q;
  logic                       last_grant_q, last_grant_d;
  logic                       err_q, err_d;

  logic [CNT_W-1:0] count;
  logic             empty;
  logic             full;
  logic             pop;
  logic             head;
  logic             elig0, elig1;
  logic             grant0, grant1;
  logic             xfer0, xfer1;
  logic             push;
  logic             push_id;

  assign count = wptr_q - rptr_q;
  assign empty = (count == '0);
  assign pop   = dram_rvalid & ~empty;
  assign head  = id_q[rptr_q[AW-1:0]];

  // A response popping in this cycle frees a slot, so a load can refill it in
  // the same cycle; this keeps a saturated read stream running at full rate.
  assign full  = (count == FULL_CNT) & ~pop;

  // Requests are ignored while reset is asserted so no handshake leaks out.
  assign elig0 = rst_b & m0_req & (m0_write | ~full);
  assign elig1 = rst_b & m1_req & (m1_write | ~full);

  // On a tie the master that did not win the last transfer gets the port.
  assign grant0 = elig0 & (~elig1 | last_grant_q);
  assign grant1 = elig1 & (~elig0 | ~last_grant_q);

  assign m0_ready = grant0 & dram_ready;
  assign m1_ready = grant1 & dram_ready;
  assign xfer0    = m0_req & m0_ready;
  assign xfer1    = m1_req & m1_ready;

  assign push    = (xfer0 & ~m0_write) | (xfer1 & ~m1_write);
  assign push_id = xfer1;

  // Request mux: master 1 fields only when it holds the grant.
  always_comb begin
    dram_req   = elig0 | elig1;
    dram_write = m0_write;
    dram_addr  = m0_addr;
    dram_wdata = m0_wdata;
    dram_wstrb = m0_wstrb;
    if (grant1) begin
      dram_write = m1_write;
      dram_addr  = m1_addr;
      dram_wdata = m1_wdata;
      dram_wstrb = m1_wstrb;
    end
  end

  // Response routing follows the ID at the FIFO head.
  assign m0_rvalid = rst_b & pop & ~head;
  assign m1_rvalid = rst_b & pop & head;
  assign m0_rdata  = dram_rdata;
  assign m1_rdata  = dram_rdata;

  assign outstanding   = count;
  assign err_unexp_rsp = err_q;

  // Next-state for pointers, round-robin history and the sticky error flag.
  always_comb begin
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    last_grant_d = last_grant_q;
    err_d        = err_q;
    if (push)                      wptr_d = wptr_q + 1'b1;
    if (pop)                       rptr_d = rptr_q + 1'b1;
    if (xfer0)                     last_grant_d = 1'b0;
    else if (xfer1)                last_grant_d = 1'b1;
    if (dram_rvalid && empty)      err_d = 1'b1;
  end

  // Control state; reset empties the FIFO and biases the first tie to master 0.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wptr_q       <= '0;
      rptr_q       <= '0;
      last_grant_q <= 1'b1;
      err_q        <= 1'b0;
    end else begin
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      last_grant_q <= last_grant_d;
      err_q        <= err_d;
    end
  end

  // ID storage; contents are only meaningful between the pointers.
  always_ff @(posedge clk) begin
    if (push) id_q[wptr_q[AW-1:0]] <= push_id;
  end

endmodule
